acumulador_notas: RTL and testbench



---
 rtl/acumulador_notas.sv | 186 ++++++++++++++++++
 tb/tb_acumulador_notas.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/acumulador_notas.sv
// acumulador_notas
// Collects one grade (0..10, values above 10 saturate to 10) per round over
// N_RODADAS rounds, keeps the running total and then computes the floor
// average by repeated subtraction, one subtraction per clock.
//
// Optional feature macro: ACUMULADOR_MINMAX_EN
//   defined   -> nota_max / nota_min track the extremes of the accepted
//                (saturated) grades of the current game.
//   undefined -> tracking logic is absent, nota_max / nota_min read 0.
//
// Handshake: iniciar is a one-cycle start/restart request, honoured in
// OCIOSO, COLETA and PRONTO and ignored in DIVIDE. nota is consumed on every
// edge where nota_valida=1 and the block is in COLETA without a coincident
// iniciar; there is no back-pressure, so a grade offered in any other state
// is simply dropped. pronto=1 marks total/media as a valid result; it stays
// high until the next iniciar.
//
// The FSM state is kept in the named signal estado_q (type estado_t) so
// checkers can bind to it directly.

module acumulador_notas #(
  parameter int N_RODADAS = 8
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       nota_valida,
  input  logic [3:0] nota,
  output logic [7:0] total,
  output logic [3:0] media,
  output logic [3:0] rodada,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] nota_max,
  output logic [3:0] nota_min
);

  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    COLETA = 2'd1,
    DIVIDE = 2'd2,
    PRONTO = 2'd3
  } estado_t;

  // Divisor in the widths of the counters it is compared with.
  localparam logic [3:0] N_RODADAS_4 = 4'(N_RODADAS);
  localparam logic [7:0] N_RODADAS_8 = 8'(N_RODADAS);
  localparam logic [3:0] NOTA_TETO   = 4'd10;

  estado_t    estado_q, estado_d;
  logic [7:0] total_q,  total_d;
  logic [3:0] media_q,  media_d;
  logic [3:0] rodada_q, rodada_d;
  logic [3:0] quoc_q,   quoc_d;
  logic [7:0] resto_q,  resto_d;

  logic [3:0] nota_sat;
  logic       aceita;
  logic       limpa;
  logic       ultima;
  logic [7:0] total_novo;

  // Grade saturation and acceptance/restart qualifiers.
  always_comb begin
    nota_sat   = (nota > NOTA_TETO) ? NOTA_TETO : nota;
    limpa      = iniciar && (estado_q != DIVIDE);
    aceita     = nota_valida && (estado_q == COLETA) && !iniciar;
    ultima     = (rodada_q == (N_RODADAS_4 - 4'd1));
    total_novo = total_q + {4'b0000, nota_sat};
  end

  // Next-state and datapath update for collection and division.
  always_comb begin
    estado_d = estado_q;
    total_d  = total_q;
    media_d  = media_q;
    rodada_d = rodada_q;
    quoc_d   = quoc_q;
    resto_d  = resto_q;

    unique case (estado_q)
      OCIOSO, PRONTO: begin
        if (limpa) begin
          estado_d = COLETA;
          total_d  = 8'd0;
          media_d  = 4'd0;
          rodada_d = 4'd0;
          quoc_d   = 4'd0;
          resto_d  = 8'd0;
        end
      end

      COLETA: begin
        if (limpa) begin
          // Restart wins over a grade offered in the same cycle.
          total_d  = 8'd0;
          media_d  = 4'd0;
          rodada_d = 4'd0;
          quoc_d   = 4'd0;
          resto_d  = 8'd0;
        end else if (aceita) begin
          total_d  = total_novo;
          rodada_d = rodada_q + 4'd1;
          if (ultima) begin
            estado_d = DIVIDE;
            resto_d  = total_novo;
            quoc_d   = 4'd0;
          end
        end
      end

      DIVIDE: begin
        if (resto_q >= N_RODADAS_8) begin
          resto_d = resto_q - N_RODADAS_8;
          quoc_d  = quoc_q + 4'd1;
        end else begin
          media_d  = quoc_q;
          estado_d = PRONTO;
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= OCIOSO;
      total_q  <= 8'd0;
      media_q  <= 4'd0;
      rodada_q <= 4'd0;
      quoc_q   <= 4'd0;
      resto_q  <= 8'd0;
    end else begin
      estado_q <= estado_d;
      total_q  <= total_d;
      media_q  <= media_d;
      rodada_q <= rodada_d;
      quoc_q   <= quoc_d;
      resto_q  <= resto_d;
    end
  end

`ifdef ACUMULADOR_MINMAX_EN
  logic [3:0] max_q, max_d;
  logic [3:0] min_q, min_d;

  // Extreme tracking of accepted grades, same timing as total.
  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (limpa) begin
      max_d = 4'd0;
      min_d = NOTA_TETO;
    end else if (aceita) begin
      if (nota_sat > max_q) max_d = nota_sat;
      if (nota_sat < min_q) min_d = nota_sat;
    end
  end

  // Extreme registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_q <= 4'd0;
      min_q <= 4'd0;
    end else begin
      max_q <= max_d;
      min_q <= min_d;
    end
  end

  assign nota_max = max_q;
  assign nota_min = min_q;
`else
  assign nota_max = 4'd0;
  assign nota_min = 4'd0;
`endif

  assign total   = total_q;
  assign media   = media_q;
  assign rodada  = rodada_q;
  assign ocupado = (estado_q == COLETA) || (estado_q == DIVIDE);
  assign pronto  = (estado_q == PRONTO);

endmodule

// File: tb/tb_acumulador_notas.sv
// Bench for acumulador_notas with N_RODADAS=4: plays games, pushes the
// expected result of each completed game into exp_q and compares it when
// pronto rises; also covers restart, ignored grades and async reset.

module tb_acumulador_notas;

  localparam int N = 4;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic       nota_valida = 1'b0;
  logic [3:0] nota = 4'd0;
  logic [7:0] total;
  logic [3:0] media;
  logic [3:0] rodada;
  logic       ocupado;
  logic       pronto;
  logic [3:0] nota_max;
  logic [3:0] nota_min;

  acumulador_notas #(.N_RODADAS(N)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .iniciar     (iniciar),
    .nota_valida (nota_valida),
    .nota        (nota),
    .total       (total),
    .media       (media),
    .rodada      (rodada),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .nota_max    (nota_max),
    .nota_min    (nota_min)
  );

  // Clock and watchdog.
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;

  // {total, media, rodada, nota_max, nota_min}
  logic [23:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare one expected result on each rising pronto.
  logic        pronto_prev = 1'b0;
  logic [23:0] e;
  always @(negedge clock) begin
    if (pronto && !pronto_prev) begin
      check("result_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("res_total",  total,    e[23:16]);
        check("res_media",  media,    e[15:12]);
        check("res_rodada", rodada,   e[11:8]);
        check("res_max",    nota_max, e[7:4]);
        check("res_min",    nota_min, e[3:0]);
      end
    end
    pronto_prev = pronto;
  end

  // Driver: optional start, four back-to-back grades, optional wait for result.
  task automatic play_game(input logic [3:0] g0, input logic [3:0] g1,
                           input logic [3:0] g2, input logic [3:0] g3,
                           input bit do_start, input bit hold_valid,
                           input bit finish);
    logic [3:0] g[4];
    logic [3:0] s;
    logic [7:0] mm;
    int sum, mx, mn, q, cycles;
    g = '{g0, g1, g2, g3};
    sum = 0; mx = 0; mn = 10;
    if (do_start) begin
      @(negedge clock); iniciar = 1'b1;
      @(negedge clock); iniciar = 1'b0;
      check("start_rodada", rodada, 0);
      check("start_total", total, 0);
      check("start_media", media, 0);
      check("start_flags", {ocupado, pronto}, 2'b10);
    end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        check("run_total", total, sum);
        check("run_rodada", rodada, i);
      end
      nota_valida = 1'b1;
      nota = g[i];
      s = (g[i] > 4'd10) ? 4'd10 : g[i];
      sum += int'(s);
      if (int'(s) > mx) mx = int'(s);
      if (int'(s) < mn) mn = int'(s);
      @(negedge clock);
    end
    nota_valida = hold_valid;
    nota = 4'd5;
    q = sum / N;
`ifdef ACUMULADOR_MINMAX_EN
    mm = {4'(mx), 4'(mn)};
`else
    mm = 8'd0;
`endif
    if (finish) begin
      exp_q.push_back({8'(sum), 4'(q), 4'(N), mm});
      cycles = 0;
      while (!pronto && cycles < 40) begin
        @(posedge clock); #1;
        cycles++;
      end
      check("latency", cycles, q + 1);
      nota_valida = 1'b0;
    end
  endtask

  // Test sequence.
  initial begin
    #1;
    check("rst_total", total, 0);
    check("rst_media", media, 0);
    check("rst_rodada", rodada, 0);
    check("rst_flags", {ocupado, pronto}, 2'b00);
    check("rst_minmax", {nota_max, nota_min}, 8'd0);
    repeat (2) @(negedge clock);
    reset_n = 1'b1;

    // Grades offered while idle are dropped.
    nota_valida = 1'b1; nota = 4'd6;
    repeat (2) @(negedge clock);
    nota_valida = 1'b0;
    check("idle_total", total, 0);
    check("idle_rodada", rodada, 0);

    play_game(4'd10, 4'd10, 4'd10, 4'd10, 1, 0, 1);
    play_game(4'd7,  4'd8,  4'd9,  4'd3,  1, 0, 1);
    play_game(4'd12, 4'd0,  4'd0,  4'd0,  1, 0, 1);

    // Restart mid-game with a coincident grade that must be dropped.
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0; nota_valida = 1'b1; nota = 4'd3;
    @(negedge clock); nota = 4'd4;
    @(negedge clock);
    check("pre_restart_total", total, 7);
    check("pre_restart_rodada", rodada, 2);
    iniciar = 1'b1; nota = 4'd9;
    @(negedge clock); iniciar = 1'b0; nota_valida = 1'b0;
    check("restart_total", total, 0);
    check("restart_rodada", rodada, 0);
    check("restart_flags", {ocupado, pronto}, 2'b10);
    play_game(4'd5, 4'd5, 4'd5, 4'd5, 0, 0, 1);

    // Grades held valid throughout DIVIDE must not disturb the result.
    play_game(4'd15, 4'd1, 4'd10, 4'd6, 1, 1, 1);

    // Asynchronous reset in the middle of the division.
    play_game(4'd10, 4'd10, 4'd10, 4'd10, 1, 0, 0);
    repeat (3) @(negedge clock);
    check("div_busy", {ocupado, pronto}, 2'b10);
    reset_n = 1'b0;
    #1;
    check("mid_rst_total", total, 0);
    check("mid_rst_media", media, 0);
    check("mid_rst_rodada", rodada, 0);
    check("mid_rst_flags", {ocupado, pronto}, 2'b00);
    check("mid_rst_minmax", {nota_max, nota_min}, 8'd0);
    @(negedge clock); reset_n = 1'b1;
    nota_valida = 1'b1; nota = 4'd7;
    repeat (3) @(negedge clock);
    nota_valida = 1'b0;
    check("post_rst_total", total, 0);
    check("post_rst_rodada", rodada, 0);
    check("post_rst_flags", {ocupado, pronto}, 2'b00);

    // Random games after recovery.
    for (int k = 0; k < 4; k++) begin
      play_game(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1, 0, 1);
    end

    repeat (3) @(negedge clock);
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
